// File: rtl/ppm_encoder.sv
// ppm_encoder: multi-channel PPM pulse-train generator.
// Each frame has NUM_CH slots followed by a final marker and sync gap.
// Every slot starts with a marker pulse that is P cycles wide.
// Slot lengths come from channel values captured at frame cycle 0.
// All outputs are registered, and timing is exact in clock cycles.
module ppm_encoder #(
  parameter int NUM_CH     = 4,
  parameter int CLK_PER_US = 50,
  parameter int PULSE_US   = 300,
  parameter int BASE_US    = 1000,
  parameter int MAX_VAL    = 1000,
  parameter int FRAME_US   = 20000
) (
  input  logic                 clk,
  input  logic                 RST,
  input  logic                 en,
  input  logic [12*NUM_CH-1:0] ch,
  output logic                 ppm,
  output logic                 frame_start,
  output logic [2:0]           chan_idx
);

  localparam int     P     = PULSE_US * CLK_PER_US;
  localparam int     F     = FRAME_US * CLK_PER_US;
  localparam longint WORST = longint'(NUM_CH) * longint'(BASE_US + MAX_VAL) * longint'(CLK_PER_US)
                             + longint'(P);
  // Counter width covers the whole frame, so slot arithmetic never wraps.
  localparam int     CW    = $clog2(F + 1);

  // Reject parameter sets whose longest possible pulse train does not fit in a frame.
  generate
    if (longint'(F) <= WORST) begin : g_bad_frame
      $error("ppm_encoder: FRAME_US too short for NUM_CH slots at MAX_VAL plus final marker");
    end
    if (NUM_CH < 1 || NUM_CH > 7) begin : g_bad_num_ch
      $error("ppm_encoder: NUM_CH must be in 1..7");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, SLOT, SYNC} state_t;

  state_t        state_reg;
  logic [CW-1:0] fc_reg;        // frame cycle, 0..F-1
  logic [CW-1:0] ic_reg;        // cycles elapsed inside current slot / sync phase
  logic [2:0]    k_reg;         // current slot index, NUM_CH during sync
  logic [CW-1:0] slen_reg [8];  // shadowed slot lengths in cycles
  logic [CW-1:0] slen_new [8];  // slot lengths computed from live channel inputs

  logic slot_end;
  logic frame_end;

  // Clamp each live channel value and convert it to a slot length in cycles.
  // Unused entries stay at zero, so k_reg can index the array without a range guard.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_slen
      if (gi < NUM_CH) begin : g_used
        logic [11:0] v;
        logic [11:0] v_clamped;
        assign v         = ch[12*gi +: 12];
        assign v_clamped = (v > 12'(MAX_VAL)) ? 12'(MAX_VAL) : v;
        assign slen_new[gi] = CW'(BASE_US * CLK_PER_US) + CW'(v_clamped) * CW'(CLK_PER_US);
      end else begin : g_unused
        assign slen_new[gi] = '0;
      end
    end
  endgenerate

  assign slot_end  = (ic_reg == slen_reg[k_reg] - CW'(1));
  assign frame_end = (fc_reg == CW'(F - 1));

  // Frame sequencer: computes next-cycle state and registers all outputs together.
  always_ff @(posedge clk) begin
    if (RST) begin
      state_reg   <= IDLE;
      fc_reg      <= '0;
      ic_reg      <= '0;
      k_reg       <= '0;
      ppm         <= 1'b0;
      frame_start <= 1'b0;
      chan_idx    <= '0;
      for (int i = 0; i < 8; i++) slen_reg[i] <= '0;
    end else begin
      frame_start <= 1'b0;
      if (state_reg == IDLE || frame_end) begin
        // Frame boundary: this is the only place where en is sampled.
        fc_reg   <= '0;
        ic_reg   <= '0;
        k_reg    <= '0;
        chan_idx <= '0;
        if (en) begin
          state_reg   <= SLOT;
          ppm         <= 1'b1;
          frame_start <= 1'b1;
          for (int i = 0; i < 8; i++) slen_reg[i] <= slen_new[i];
        end else begin
          state_reg <= IDLE;
          ppm       <= 1'b0;
        end
      end else if (state_reg == SLOT && slot_end) begin
        // Slot boundary: move to the next slot and start its marker on the next cycle.
        fc_reg   <= fc_reg + CW'(1);
        ic_reg   <= '0;
        ppm      <= 1'b1;
        k_reg    <= k_reg + 3'd1;
        chan_idx <= k_reg + 3'd1;
        if (k_reg == 3'(NUM_CH - 1)) state_reg <= SYNC;
      end else begin
        fc_reg <= fc_reg + CW'(1);
        ic_reg <= ic_reg + CW'(1);
        ppm    <= (ic_reg < CW'(P - 1));
      end
    end
  end

endmodule

// File: tb/tb_ppm_encoder.sv
// Directed testbench for ppm_encoder.
// It uses CLK_PER_US=1 and a 10000-cycle frame, so the runs stay short.
// Edge positions are hand-computed from slot_k = 1000 + min(v_k, 1000) cycles.
module tb_ppm_encoder;

  localparam int F = 10000;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [47:0] ch;
  logic        ppm;
  logic        frame_start;
  logic [2:0]  chan_idx;

  int passes = 0;
  int total  = 0;

  bit         ppm_log [F];
  bit         fs_log  [F];
  logic [2:0] ci_log  [F];

  ppm_encoder #(
    .NUM_CH(4), .CLK_PER_US(1), .PULSE_US(300), .BASE_US(1000),
    .MAX_VAL(1000), .FRAME_US(10000)
  ) dut (
    .clk(clk), .RST(rst), .en(en), .ch(ch),
    .ppm(ppm), .frame_start(frame_start), .chan_idx(chan_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Record one frame, starting at the negedge where frame cycle 0 is visible.
  // Optional inputs can change mid-frame.
  task automatic capture(input int chg_at, input logic [47:0] chg_val, input int drop_at);
    for (int i = 0; i < F; i++) begin
      ppm_log[i] = ppm;
      fs_log[i]  = frame_start;
      ci_log[i]  = chan_idx;
      if (i == chg_at)  ch = chg_val;
      if (i == drop_at) en = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic check_frame(input string name, input int e0, input int e1, input int e2,
                             input int e3, input int e4);
    int exp_e [5];
    int got   [5];
    int wid   [5];
    int n;
    int fsn;
    int w;
    exp_e = '{e0, e1, e2, e3, e4};
    got   = '{-1, -1, -1, -1, -1};
    wid   = '{-1, -1, -1, -1, -1};
    n     = 0;
    fsn   = 0;
    for (int i = 0; i < F; i++) begin
      if (fs_log[i]) fsn++;
      if (ppm_log[i] && (i == 0 || !ppm_log[i-1])) begin
        if (n < 5) begin
          w = 0;
          while (i + w < F && ppm_log[i+w]) w++;
          got[n] = i;
          wid[n] = w;
        end
        n++;
      end
    end
    chk($sformatf("%s edge_count", name), n, 5);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("%s edge%0d", name, k), got[k], exp_e[k]);
      chk($sformatf("%s width%0d", name, k), wid[k], 300);
    end
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("%s chan_idx@S%0d", name, k), ci_log[exp_e[k]], k);
      chk($sformatf("%s chan_idx@S%0d-1", name, k + 1), ci_log[exp_e[k+1]-1], k);
    end
    chk($sformatf("%s chan_idx@S4", name), ci_log[e4], 4);
    chk($sformatf("%s chan_idx@F-1", name), ci_log[F-1], 4);
    chk($sformatf("%s frame_start_count", name), fsn, 1);
    chk($sformatf("%s frame_start@0", name), fs_log[0], 1);
  endtask

  initial begin
    int hits;

    // Reset state
    rst = 1'b1;
    en  = 1'b0;
    ch  = {12'd250, 12'd1000, 12'd500, 12'd0};
    repeat (3) @(negedge clk);
    chk("reset ppm", ppm, 0);
    chk("reset frame_start", frame_start, 0);
    chk("reset chan_idx", chan_idx, 0);

    // Start: en is seen at the next posedge, so frame cycle 0 appears one cycle later.
    rst = 1'b0;
    en  = 1'b1;
    @(negedge clk);

    // Nominal frame. ch1 changes 500 -> 0 at cycle 1200, which must not affect this frame.
    capture(1200, {12'd250, 12'd1000, 12'd0, 12'd0}, -1);
    check_frame("nominal", 0, 1000, 2500, 4500, 5750);

    // Next frame uses ch1=0. ch0 becomes 4095 for the following frame.
    capture(100, {12'd250, 12'd1000, 12'd0, 12'd4095}, -1);
    check_frame("update", 0, 1000, 2000, 4000, 5250);

    // Clamp frame (4095 -> 1000). en drops at cycle 3000, but the frame completes.
    capture(-1, ch, 3000);
    check_frame("clamp_endrop", 0, 2000, 3000, 5000, 6250);
    chk("idle ppm", ppm, 0);
    chk("idle frame_start", frame_start, 0);
    chk("idle chan_idx", chan_idx, 0);
    hits = 0;
    for (int i = 0; i < 100; i++) begin
      if (ppm || frame_start) hits++;
      @(negedge clk);
    end
    chk("idle activity", hits, 0);

    // Re-enable from IDLE: frame cycle 0 appears one cycle after en is sampled.
    en = 1'b1;
    @(negedge clk);
    chk("reenable frame_start", frame_start, 1);
    chk("reenable ppm", ppm, 1);
    chk("reenable chan_idx", chan_idx, 0);

    // Move to frame cycle 3100, which is inside the marker for slot 2.
    repeat (3100) @(negedge clk);
    chk("midpulse ppm", ppm, 1);
    chk("midpulse chan_idx", chan_idx, 2);
    rst = 1'b1;
    @(negedge clk);
    chk("rst ppm", ppm, 0);
    chk("rst chan_idx", chan_idx, 0);
    chk("rst frame_start", frame_start, 0);

    // Release reset with en=1. A fresh frame starts one cycle later.
    rst = 1'b0;
    @(negedge clk);
    capture(-1, ch, -1);
    check_frame("after_reset", 0, 2000, 3000, 5000, 6250);
    chk("frame_length next frame_start", frame_start, 1);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

// File: doc/ppm_encoder.md
Name: ppm_encoder

Overview:
Generates a standard multi-channel PPM pulse train from NUM_CH 12-bit channel values. It is the transmit-side counterpart of ppm_decoder, using the same channel scale (0..1000, 500 = centre). It serves as the stimulus source for decoder and motor-controller benches and as the PPM output when the board relays stick data downstream. All outputs are registered, and timing is exact in clock cycles.

Parameters:
NUM_CH, 4, number of channels per frame (1..7)
CLK_PER_US, 50, clock cycles per microsecond
PULSE_US, 300, width of each high marker pulse, in µs
BASE_US, 1000, slot length at channel value 0, in µs
MAX_VAL, 1000, channel value clamp ceiling
FRAME_US, 20000, total frame period, in µs

Ports:
clk  in  1  system clock
RST  in  1  synchronous active-high reset
en  in  1  enable; sampled only at frame boundaries
ch  in  12*NUM_CH  channel values, flattened; ch[12k+11:12k] is channel k
ppm  out  1  PPM output; high = marker pulse
frame_start  out  1  one-cycle strobe on the first cycle of each frame
chan_idx  out  3  slot currently being emitted: 0..NUM_CH-1, or NUM_CH during the final marker and sync gap

Behaviour:
- Derived constants (cycles): P = PULSE_US*CLK_PER_US; F = FRAME_US*CLK_PER_US; slot_k = (BASE_US + v_k)*CLK_PER_US, where v_k = min(ch_k, MAX_VAL), compared unsigned.
- Elaboration check: F > NUM_CH*(BASE_US+MAX_VAL)*CLK_PER_US + P. If violated, fail with $error.
- Reset: state IDLE; ppm=0, frame_start=0, chan_idx=0; all counters 0. Reset takes effect mid-frame or mid-pulse, and outputs are 0 on the cycle after RST is sampled high.
- States:
  - IDLE: ppm=0, chan_idx=0. If en=1, the next cycle is frame cycle 0.
  - SLOT: emitting channel k.
  - SYNC: final marker plus gap.
- Frame cycle counter fc runs 0..F-1.
  - At fc=0: all NUM_CH channel values are latched, clamped, into shadow registers. frame_start=1 for that cycle only.
  - Changes to ch after fc=0 have no effect until the next frame.
- Edge times: S_0 = 0 and S_{k+1} = S_k + slot_k.
  - ppm=1 on frame cycles [S_k, S_k+P) for k = 0..NUM_CH, giving NUM_CH+1 marker pulses.
  - ppm=0 on all other cycles.
- chan_idx = k during [S_k, S_{k+1}) for k < NUM_CH, and NUM_CH from S_NUM_CH through F-1.
- Slot counter reloads at each slot boundary. No cycle is inserted or dropped between slots, and the frame length is exactly F cycles regardless of channel values.
- Frame end (fc=F-1):
  - en=1 → the next cycle is fc=0 of a new frame, with frame_start=1 and ppm=1.
  - en=0 → go to IDLE, ppm=0.
- A deassertion of en mid-frame never truncates the current frame.
- Channel value 0 gives a minimum slot of BASE_US. Values above MAX_VAL, including 4095, are treated as MAX_VAL. No wrap in the slot arithmetic (counter width ≥ clog2(F)).
- en rising while IDLE: frame cycle 0 occurs on the cycle after en is first sampled high.

Test Plan:
- Nominal timing. Params CLK_PER_US=1, defaults otherwise; ch = {0, 500, 1000, 250}, en=1 → ppm rising edges at frame cycles 0, 1000, 2500, 4500, 5750; each pulse 300 cycles wide; frame_start at cycles 0, 20000, 40000; chan_idx = 4 from cycle 5750.
- Clamp. ch0 = 4095, others 0 → second rising edge at cycle 2000 (as for 1000); frame length still 20000.
- Mid-frame update. Change ch1 from 500 to 0 at frame cycle 1200 → current frame edges unchanged (2500); next frame edge at 20000+2000.
- Enable drop. en=0 at frame cycle 3000 → current frame completes with all 5 pulses; ppm=0 and no frame_start from cycle 20000. en=1 again at cycle 30000 → frame_start=1 and ppm=1 at cycle 30001.
- Reset mid-pulse. Assert RST during frame cycle 2600 → ppm=0, chan_idx=0 next cycle. Release with en=1 → fresh frame starts with frame_start one cycle after release.
- Decoder loopback. Drive ppm_encoder into ppm_decoder at CLK_PER_US=50 with ch = {190, 400, 999, 500} → decoder outputs match within ±1 after the second frame.
